mant_mul_arbiter: RTL and testbench
===================================

// Module: mant_mul_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 24x24 mantissa multiplier among NUM_REQ
//  FP controllers (FP multiply, divide/sqrt iteration). Sits between the controllers'
//  Multi_* callee interfaces and the multiplier's Multi_* port.
//  Serialises one operation at a time and returns product and exception to the granted requester.
// PARAMETERS
//  NUM_REQ         2    number of requesters (2..8)
//  TIMEOUT_CYCLES  64   max cycles in ARB_WAIT before abort (only with MUL_ARB_TIMEOUT_EN)
// PORTS
//  CLK           in   1            clock, rising edge
//  RST           in   1            asynchronous, active-high reset
//  Req_valid     in   NUM_REQ      per-requester request, level, held until own Req_ack
//  Req_datain1   in   NUM_REQ*24   packed operand A, slice i = [24i+23:24i]
//  Req_datain2   in   NUM_REQ*24   packed operand B, same packing
//  Req_ack       out  NUM_REQ      one-hot 1-cycle completion pulse
//  Req_dataout   out  48           product, valid only while Req_ack!=0 (broadcast)
//  Req_exc       out  3            exception code, valid with Req_ack (broadcast)
//  Multi_datain1 out  24           operand A to multiplier
//  Multi_datain2 out  24           operand B to multiplier
//  Multi_valid   out  1            request to multiplier, held until Multi_ack
//  Multi_dataout in   48           multiplier product
//  Multi_Exc     in   3            multiplier exception code
//  Multi_ack     in   1            multiplier done, 1-cycle pulse
//  Grant         out  NUM_REQ      one-hot current owner, 0 when idle (debug)
//  Busy          out  1            1 in any state except ARB_IDLE
// BEHAVIOUR
//  Reset (async, immediate): state ARB_IDLE, rr pointer 0, all outputs 0.
//  All outputs registered. States:
//   ARB_IDLE: if any Req_valid, pick first set bit at/after rr pointer (wrapping), latch
//     index + operands, set Grant -> ARB_WAIT. Else stay.
//   ARB_WAIT: Multi_valid=1, Multi_datain1/2 = latched operands (stable).
//     On Multi_ack: capture Multi_dataout/Multi_Exc, Multi_valid=0 next cycle -> ARB_RESPOND.
//   ARB_RESPOND: Req_ack[grant]=1, Req_dataout/Req_exc = captured values for exactly 1 cycle;
//     rr pointer = (grant+1) mod NUM_REQ; Grant=0 -> ARB_IDLE.
//  Latency: Req_valid seen at cycle 0 -> Multi_valid at cycle 1 -> Req_ack 2 cycles after Multi_ack.
//  Throughput: one op per (multiplier latency + 3) cycles; no overlap.
//  Requesters must drop Req_valid the cycle after Req_ack; a valid still high in
//   ARB_IDLE is treated as a new request.
//  Withdrawn request (Req_valid falls after grant): op completes, Req_ack still pulsed.
//  Operand changes after grant ignored (latched copy used).
//  Multi_ack outside ARB_WAIT ignored. Simultaneous requests: rr order only; no starvation,
//   each requester served within NUM_REQ ops.
//  Multi_Exc passed through unchanged (000 = none). Product passed through, no normalisation.
// CONFIGURATION
//  MUL_ARB_TIMEOUT_EN defined: counter runs in ARB_WAIT; on reaching TIMEOUT_CYCLES without
//   Multi_ack, Multi_valid drops -> ARB_RESPOND with Req_dataout=0, Req_exc=3'b111.
//  Undefined: no counter; ARB_WAIT waits indefinitely; 3'b111 never generated.
// STRUCTURE
//  Package mul_arb_pkg: enum mul_arb_state_t {ARB_IDLE, ARB_WAIT, ARB_RESPOND};
//   MANT_W=24, PROD_W=48; EXC_NONE=3'b000, EXC_TIMEOUT=3'b111.
//  Sub-module rr_pick (combinational): inputs req vector + pointer, outputs one-hot
//   grant + index + any_req.
//  Top: state register, operand/result latches, rr pointer, optional timeout counter.
// TESTING
//  1 Single req: Req_valid=01, A=24'h800000, B=24'hC00000, mult acks after 3 cyc with
//    48'h600000000000 -> Req_ack=01 with that product, Req_exc=0, 2 cyc after Multi_ack.
//  2 Contention: Req_valid=11 held, ptr=0 -> grants 01,10,01,10 alternating; no double ack.
//  3 Exception: Multi_Exc=3'b010 with Multi_ack -> Req_exc=3'b010 on requester's Req_ack.
//  4 Async reset mid ARB_WAIT -> Multi_valid, Grant, Busy 0 same cycle; later late Multi_ack
//    ignored, no Req_ack.
//  5 Operand change after grant: Req_datain1 altered in ARB_WAIT -> Multi_datain1 unchanged.
//  6 With MUL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no Multi_ack -> Multi_valid low after 8 cyc,
//    Req_ack pulse with Req_exc=3'b111, Req_dataout=0.

Source files
------------

// File: rtl/mant_mul_arbiter_pkg.sv
// Shared types and constants for the mantissa-multiplier arbiter.
package mul_arb_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned PROD_W = 48;
    localparam int unsigned EXC_W  = 3;

    localparam logic [EXC_W-1:0] EXC_NONE    = 3'b000;
    localparam logic [EXC_W-1:0] EXC_TIMEOUT = 3'b111;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_RESPOND
    } mul_arb_state_t;

    // Index width that stays at least one bit for degenerate counts.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mant_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at/after ptr, wrapping.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    always_comb begin
        int unsigned j;
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = 32'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any_c && req[IDX_W'(j)]) begin
                any_c              = 1'b1;
                gnt_c[IDX_W'(j)]   = 1'b1;
                idx_c              = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mant_mul_arbiter.sv
// Round-robin sequencer sharing one 24x24 mantissa multiplier among NUM_REQ controllers.
// Define MUL_ARB_TIMEOUT_EN to abort a multiplier wait after TIMEOUT_CYCLES with EXC_TIMEOUT.
module mant_mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        Req_valid,
    input  logic [NUM_REQ*MANT_W-1:0] Req_datain1,
    input  logic [NUM_REQ*MANT_W-1:0] Req_datain2,
    output logic [NUM_REQ-1:0]        Req_ack,
    output logic [PROD_W-1:0]         Req_dataout,
    output logic [EXC_W-1:0]          Req_exc,
    output logic [MANT_W-1:0]         Multi_datain1,
    output logic [MANT_W-1:0]         Multi_datain2,
    output logic                      Multi_valid,
    input  logic [PROD_W-1:0]         Multi_dataout,
    input  logic [EXC_W-1:0]          Multi_Exc,
    input  logic                      Multi_ack,
    output logic [NUM_REQ-1:0]        Grant,
    output logic                      Busy
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mant_mul_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    mul_arb_state_t     state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [PROD_W-1:0]  res_q;
    logic [EXC_W-1:0]   exc_q;

    logic [NUM_REQ-1:0] pick_gnt_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               pick_any_c;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = idx_width(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (Req_valid),
        .ptr   (rr_ptr),
        .gnt_c (pick_gnt_c),
        .idx_c (pick_idx_c),
        .any_c (pick_any_c)
    );

    // Sequencer: grant, hold operands for the multiplier, then return result for one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ARB_IDLE;
            rr_ptr        <= '0;
            gnt_idx       <= '0;
            res_q         <= '0;
            exc_q         <= EXC_NONE;
            Req_ack       <= '0;
            Req_dataout   <= '0;
            Req_exc       <= EXC_NONE;
            Multi_datain1 <= '0;
            Multi_datain2 <= '0;
            Multi_valid   <= 1'b0;
            Grant         <= '0;
            Busy          <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            Req_ack     <= '0;
            Req_dataout <= '0;
            Req_exc     <= EXC_NONE;
            unique case (state)
                ARB_IDLE: begin
                    if (pick_any_c) begin
                        gnt_idx       <= pick_idx_c;
                        Grant         <= pick_gnt_c;
                        Multi_datain1 <= Req_datain1[MANT_W*pick_idx_c +: MANT_W];
                        Multi_datain2 <= Req_datain2[MANT_W*pick_idx_c +: MANT_W];
                        Multi_valid   <= 1'b1;
                        Busy          <= 1'b1;
                        state         <= ARB_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
                        tmo_cnt       <= '0;
`endif
                    end
                end
                ARB_WAIT: begin
                    if (Multi_ack) begin
                        res_q       <= Multi_dataout;
                        exc_q       <= Multi_Exc;
                        Multi_valid <= 1'b0;
                        state       <= ARB_RESPOND;
                    end
`ifdef MUL_ARB_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        res_q       <= '0;
                        exc_q       <= EXC_TIMEOUT;
                        Multi_valid <= 1'b0;
                        state       <= ARB_RESPOND;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end
                ARB_RESPOND: begin
                    Req_ack     <= Grant;
                    Req_dataout <= res_q;
                    Req_exc     <= exc_q;
                    rr_ptr      <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                    Grant       <= '0;
                    Busy        <= 1'b0;
                    state       <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mant_mul_arbiter.sv
// Directed scoreboard bench for mant_mul_arbiter (NUM_REQ=2); timeout case needs MUL_ARB_TIMEOUT_EN.
module tb_mant_mul_arbiter;

    logic        CLK;
    logic        RST;
    logic [1:0]  Req_valid;
    logic [47:0] Req_datain1;
    logic [47:0] Req_datain2;
    logic [1:0]  Req_ack;
    logic [47:0] Req_dataout;
    logic [2:0]  Req_exc;
    logic [23:0] Multi_datain1;
    logic [23:0] Multi_datain2;
    logic        Multi_valid;
    logic [47:0] Multi_dataout;
    logic [2:0]  Multi_Exc;
    logic        Multi_ack;
    logic [1:0]  Grant;
    logic        Busy;

    typedef struct packed {
        logic [1:0]  ack;
        logic [47:0] prod;
        logic [2:0]  exc;
    } exp_t;

    exp_t sb[$];
    exp_t sb_e;
    int   checks = 0;
    int   errors = 0;

    mant_mul_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .Req_valid     (Req_valid),
        .Req_datain1   (Req_datain1),
        .Req_datain2   (Req_datain2),
        .Req_ack       (Req_ack),
        .Req_dataout   (Req_dataout),
        .Req_exc       (Req_exc),
        .Multi_datain1 (Multi_datain1),
        .Multi_datain2 (Multi_datain2),
        .Multi_valid   (Multi_valid),
        .Multi_dataout (Multi_dataout),
        .Multi_Exc     (Multi_Exc),
        .Multi_ack     (Multi_ack),
        .Grant         (Grant),
        .Busy          (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (Req_ack !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", 64'(Req_ack), 64'd0);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_ack",  64'(Req_ack),     64'(sb_e.ack));
                chk("sb_prod", 64'(Req_dataout), 64'(sb_e.prod));
                chk("sb_exc",  64'(Req_exc),     64'(sb_e.exc));
            end
        end
    end

    // Multiplier model plus latency checks for one granted operation.
    task automatic serve(input logic [1:0] exp_gnt, input logic [23:0] exp_a, input logic [23:0] exp_b,
                         input int lat, input logic [2:0] exc, input string tag);
        int waited = 0;
        while (!Multi_valid && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        chk({tag, "_mv"},   64'(Multi_valid),   64'd1);
        chk({tag, "_gnt"},  64'(Grant),         64'(exp_gnt));
        chk({tag, "_opa"},  64'(Multi_datain1), 64'(exp_a));
        chk({tag, "_opb"},  64'(Multi_datain2), 64'(exp_b));
        chk({tag, "_busy"}, 64'(Busy),          64'd1);
        repeat (lat) @(negedge CLK);
        Multi_ack     = 1'b1;
        Multi_dataout = 48'(Multi_datain1) * 48'(Multi_datain2);
        Multi_Exc     = exc;
        @(negedge CLK);
        Multi_ack     = 1'b0;
        Multi_dataout = '0;
        Multi_Exc     = '0;
        chk({tag, "_resp_mv"},  64'(Multi_valid), 64'd0);
        chk({tag, "_resp_ack"}, 64'(Req_ack),     64'd0);
        @(negedge CLK);
        chk({tag, "_ack"}, 64'(Req_ack), 64'(exp_gnt));
    endtask

    initial begin
        logic [23:0] a, b, a0, b0, a1, b1;
        RST           = 1'b1;
        Req_valid     = '0;
        Req_datain1   = '0;
        Req_datain2   = '0;
        Multi_dataout = '0;
        Multi_Exc     = '0;
        Multi_ack     = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_busy",  64'(Busy),        64'd0);
        chk("rst_grant", 64'(Grant),       64'd0);
        chk("rst_mv",    64'(Multi_valid), 64'd0);
        chk("rst_ack",   64'(Req_ack),     64'd0);
        chk("rst_dout",  64'(Req_dataout), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Single request, multiplier answers after 3 cycles.
        a = 24'h800000;
        b = 24'hC00000;
        Req_datain1[23:0] = a;
        Req_datain2[23:0] = b;
        Req_valid = 2'b01;
        sb.push_back('{2'b01, 48'h600000000000, 3'b000});
        @(negedge CLK);
        chk("t1_mv_latency", 64'(Multi_valid), 64'd1);
        serve(2'b01, a, b, 3, 3'b000, "t1");
        Req_valid = 2'b00;
        @(negedge CLK);
        chk("t1_idle_busy", 64'(Busy),    64'd0);
        chk("t1_ack_clear", 64'(Req_ack), 64'd0);

        // Exception pass-through on requester 1.
        a = 24'hA5A5A5;
        b = 24'h00F00F;
        Req_datain1[47:24] = a;
        Req_datain2[47:24] = b;
        Req_valid = 2'b10;
        sb.push_back('{2'b10, 48'(a) * 48'(b), 3'b010});
        serve(2'b10, a, b, 2, 3'b010, "t3");
        Req_valid = 2'b00;
        @(negedge CLK);

        // Contention with both held, pointer back at 0.
        a0 = 24'h123456; b0 = 24'h654321;
        a1 = 24'hFFFFFF; b1 = 24'hFFFFFF;
        Req_datain1 = {a1, a0};
        Req_datain2 = {b1, b0};
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb.push_back('{2'b01, 48'(a0) * 48'(b0), 3'b000});
            else            sb.push_back('{2'b10, 48'hFFFFFE000001, 3'b000});
        end
        Req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) serve(2'b01, a0, b0, 1, 3'b000, "t2_r0");
            else            serve(2'b10, a1, b1, 1, 3'b000, "t2_r1");
        end
        Req_valid = 2'b00;
        repeat (2) @(negedge CLK);
        chk("t2_idle_busy", 64'(Busy), 64'd0);

        // Operands changed and request withdrawn after grant.
        a = 24'h400000;
        b = 24'h400001;
        Req_datain1[23:0] = a;
        Req_datain2[23:0] = b;
        Req_valid = 2'b01;
        sb.push_back('{2'b01, 48'(a) * 48'(b), 3'b000});
        @(negedge CLK);
        Req_datain1[23:0] = 24'hFFFFFF;
        Req_datain2[23:0] = 24'h000001;
        Req_valid = 2'b00;
        @(negedge CLK);
        chk("t5_hold_opa", 64'(Multi_datain1), 64'(a));
        serve(2'b01, a, b, 1, 3'b000, "t5");
        @(negedge CLK);

        // Async reset in the middle of a multiplier wait, then a stale Multi_ack.
        Req_datain1[23:0] = 24'h000003;
        Req_datain2[23:0] = 24'h000005;
        Req_valid = 2'b01;
        @(negedge CLK);
        chk("t4_mv_before", 64'(Multi_valid), 64'd1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("t4_rst_mv",    64'(Multi_valid), 64'd0);
        chk("t4_rst_grant", 64'(Grant),       64'd0);
        chk("t4_rst_busy",  64'(Busy),        64'd0);
        Req_valid = 2'b00;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        Multi_ack     = 1'b1;
        Multi_dataout = 48'hDEAD_BEEF_0001;
        @(negedge CLK);
        Multi_ack     = 1'b0;
        Multi_dataout = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("t4_no_ack",  64'(Req_ack), 64'd0);
            chk("t4_no_busy", 64'(Busy),    64'd0);
        end

`ifdef MUL_ARB_TIMEOUT_EN
        // Multiplier never answers: abort after 8 wait cycles.
        begin
            int hi = 0;
            int guard = 0;
            Req_datain1[47:24] = 24'h111111;
            Req_datain2[47:24] = 24'h222222;
            Req_valid = 2'b10;
            sb.push_back('{2'b10, 48'h0, 3'b111});
            @(negedge CLK);
            while (Multi_valid && guard < 40) begin
                hi++;
                guard++;
                @(negedge CLK);
            end
            chk("t6_mv_cycles", 64'(hi), 64'd8);
            chk("t6_resp_ack",  64'(Req_ack), 64'd0);
            @(negedge CLK);
            chk("t6_ack", 64'(Req_ack), 64'd2);
            Req_valid = 2'b00;
            @(negedge CLK);
        end
`endif

        repeat (2) @(negedge CLK);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
